// File: rtl/disp_src_arbiter.sv
// Round-robin arbiter sharing the seven-segment display between four BCD sources.
// A granted word is latched and held for HOLD_CYC cycles before the next grant.
module disp_src_arbiter #(
   parameter int unsigned HOLD_CYC = 50_000_000,
   parameter int unsigned CNT_W    = 26
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [31:0] data3,
   input  logic        freeze,
   output logic [3:0]  ack,
   output logic [31:0] disp_data,
   output logic [1:0]  disp_src,
   output logic        busy
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       last;
   logic [1:0]       win;
   logic [31:0]      win_data;

   // First requester after ptr, wrapping; ptr itself is searched last.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = ptr;
      for (int k = 4; k >= 1; k--) begin
         idx = ptr + 2'(k);
         if (r[idx]) pick = idx;
      end
      return pick;
   endfunction

   always_comb begin
      win = rr_pick(req, last);
      case (win)
         2'd0:    win_data = data0;
         2'd1:    win_data = data1;
         2'd2:    win_data = data2;
         default: win_data = data3;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state     <= IDLE;
         disp_data <= '0;
         disp_src  <= '0;
         ack       <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
         last      <= 2'd3;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  disp_data <= win_data;
                  disp_src  <= win;
                  ack       <= 4'b0001 << win;
                  last      <= win;
                  cnt       <= HOLD_LOAD;
                  busy      <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               ack <= '0;
               // Freeze stalls the dwell, including on its final cycle.
               if (!freeze) begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Directed bench for disp_src_arbiter: grants are scoreboarded (source, word, cycle),
// dwell/freeze/reset behaviour is checked cycle by cycle.
module tb_disp_src_arbiter;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [3:0]  req    = 4'h0;
   logic [3:0]  req8   = 4'h0;
   logic [31:0] data0  = 32'hA000_0001;
   logic [31:0] data1  = 32'hB111_0002;
   logic [31:0] data2  = 32'h1234_5678;
   logic [31:0] data3  = 32'h8765_4321;
   logic        freeze = 1'b0;

   logic [3:0]  ack4, ack8;
   logic [31:0] dd4, dd8;
   logic [1:0]  src4, src8;
   logic        busy4, busy8;

   int cyc   = 0;
   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [3:0]  ack;
      logic [1:0]  src;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   exp_t e4, e8;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   disp_src_arbiter #(.HOLD_CYC(4), .CNT_W(8)) dut4 (
      .Clk(clk), .Rst_n(rst_n), .req(req),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .freeze(freeze), .ack(ack4), .disp_data(dd4), .disp_src(src4), .busy(busy4)
   );

   disp_src_arbiter #(.HOLD_CYC(8), .CNT_W(3)) dut8 (
      .Clk(clk), .Rst_n(rst_n), .req(req8),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .freeze(freeze), .ack(ack8), .disp_data(dd8), .disp_src(src8), .busy(busy8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [3:0] a, input logic [1:0] s,
                               input logic [31:0] d, input int c);
      exp_t e;
      e.ack  = a;
      e.src  = s;
      e.data = d;
      e.cyc  = c;
      return e;
   endfunction

   function automatic logic [31:0] dsel(input int i);
      case (i)
         0:       return data0;
         1:       return data1;
         2:       return data2;
         default: return data3;
      endcase
   endfunction

   always @(negedge clk) begin
      if (ack4 != 4'b0000) begin
         if (q4.size() == 0) begin
            check("dut4_unexpected_ack", 64'(ack4), 64'd0);
         end else begin
            e4 = q4.pop_front();
            check("dut4_ack", 64'(ack4), 64'(e4.ack));
            check("dut4_src", 64'(src4), 64'(e4.src));
            check("dut4_data", 64'(dd4), 64'(e4.data));
            check("dut4_grant_cycle", 64'(cyc), 64'(e4.cyc));
            check("dut4_busy_at_grant", 64'(busy4), 64'd1);
         end
      end
      if (ack8 != 4'b0000) begin
         if (q8.size() == 0) begin
            check("dut8_unexpected_ack", 64'(ack8), 64'd0);
         end else begin
            e8 = q8.pop_front();
            check("dut8_ack", 64'(ack8), 64'(e8.ack));
            check("dut8_src", 64'(src8), 64'(e8.src));
            check("dut8_data", 64'(dd8), 64'(e8.data));
            check("dut8_grant_cycle", 64'(cyc), 64'(e8.cyc));
            check("dut8_busy_at_grant", 64'(busy8), 64'd1);
         end
      end
   end

   initial begin
      int base;

      // Reset held 3 cycles with all requests high
      req = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_disp_data", 64'(dd4), 64'd0);
         check("rst_disp_src", 64'(src4), 64'd0);
         check("rst_ack", 64'(ack4), 64'd0);
         check("rst_busy", 64'(busy4), 64'd0);
      end
      rst_n = 1'b1;
      q4.push_back(mk(4'b0001, 2'd0, data0, cyc + 1));
      tick();
      req = 4'h0;
      for (int i = 0; i < 4; i++) tick();
      check("rst_first_dwell_end", 64'(busy4), 64'd0);

      // Single grant of source 2, then data2 changes after the grant
      req  = 4'b0100;
      base = cyc;
      q4.push_back(mk(4'b0100, 2'd2, 32'h1234_5678, base + 1));
      tick();
      req   = 4'h0;
      data2 = 32'hDEAD_BEEF;
      check("single_busy_c1", 64'(busy4), 64'd1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check("single_busy_dwell", 64'(busy4), 64'd1);
         if (i == 2) check("single_ack_cleared", 64'(ack4), 64'd0);
      end
      tick();
      check("single_busy_low", 64'(busy4), 64'd0);
      check("single_data_held", 64'(dd4), 64'h1234_5678);
      check("single_src_held", 64'(src4), 64'd2);
      tick();
      check("single_data_held_idle", 64'(dd4), 64'h1234_5678);

      // Round robin under continuous requests after a pointer reset
      rst_n = 1'b0;
      tick();
      check("rr_rst_data", 64'(dd4), 64'd0);
      check("rr_rst_src", 64'(src4), 64'd0);
      rst_n = 1'b1;
      req   = 4'hF;
      base  = cyc;
      for (int k = 0; k < 5; k++)
         q4.push_back(mk(4'(1 << (k % 4)), 2'(k % 4), dsel(k % 4), base + 1 + 5 * k));
      for (int i = 1; i <= 21; i++) begin
         tick();
         if (i % 5 == 0) check("rr_idle_gap", 64'(busy4), 64'd0);
      end
      req = 4'h0;
      for (int i = 0; i < 4; i++) tick();
      check("rr_final_idle", 64'(busy4), 64'd0);
      check("rr_all_grants_seen", 64'(q4.size()), 64'd0);

      // Request raised during an 8-cycle dwell waits for IDLE
      req8 = 4'b0010;
      base = cyc;
      q8.push_back(mk(4'b0010, 2'd1, data1, base + 1));
      q8.push_back(mk(4'b1000, 2'd3, data3, base + 10));
      tick();
      req8 = 4'h0;
      tick();
      tick();
      req8 = 4'b1000;
      for (int i = 3; i < 10; i++) begin
         check("hold_req_no_early_ack", 64'(ack8), 64'd0);
         tick();
      end
      req8 = 4'h0;
      for (int i = 0; i < 7; i++) tick();
      check("hold8_busy_last", 64'(busy8), 64'd1);
      tick();
      check("hold8_busy_low", 64'(busy8), 64'd0);

      // Freeze for 3 cycles stretches the dwell by 3
      req  = 4'b0010;
      base = cyc;
      q4.push_back(mk(4'b0010, 2'd1, data1, base + 1));
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 1) req = 4'h0;
         if (i == 2) freeze = 1'b1;
         if (i == 5) freeze = 1'b0;
         check("freeze_busy", 64'(busy4), 64'(i <= 7));
      end
      check("freeze_idle_other", 64'(busy8), 64'd0);

      // Reset in the third dwell cycle with source 1 pending
      req  = 4'b0100;
      base = cyc;
      q4.push_back(mk(4'b0100, 2'd2, data2, base + 1));
      tick();
      req = 4'h0;
      tick();
      req = 4'b0010;
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst_busy", 64'(busy4), 64'd0);
      check("midrst_data", 64'(dd4), 64'd0);
      check("midrst_ack", 64'(ack4), 64'd0);
      check("midrst_src", 64'(src4), 64'd0);
      rst_n = 1'b1;
      q4.push_back(mk(4'b0010, 2'd1, data1, cyc + 1));
      tick();
      req = 4'h0;
      check("midrst_regrant_src", 64'(src4), 64'd1);
      for (int i = 0; i < 4; i++) tick();
      check("midrst_dwell_end", 64'(busy4), 64'd0);

      check("dut4_queue_drained", 64'(q4.size()), 64'd0);
      check("dut8_queue_drained", 64'(q8.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
